// File: rtl/pc_gen.sv
// pc_gen: fetch-side PC generator with prioritised redirects, vectored trap entry and epoch tagging
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   pc_o, epoch_o, pc_valid_o       fetch PC offered to IF, its epoch tag, request valid
//   pc_ready_i                      IF accepts pc_o this cycle
//   br_taken_i, br_target_i         resolved taken branch/jump and its target
//   trap_i, trap_intr_i,
//   trap_cause_i, mtvec_i           trap entry request, interrupt flag, cause, mtvec CSR
//   mret_i, mepc_i                  mret request and mepc CSR
//   halt_i                          ebreak/halt request
//   misalign_o, misalign_addr_o     one-cycle misaligned-branch pulse and captured target
module pc_gen #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = 32'h8000_0000,
    parameter int                 EPOCH_W   = 2,
    parameter int                 CAUSE_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [WIDTH-1:0]   pc_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               pc_valid_o,
    input  logic               pc_ready_i,
    input  logic               br_taken_i,
    input  logic [WIDTH-1:0]   br_target_i,
    input  logic               trap_i,
    input  logic               trap_intr_i,
    input  logic [CAUSE_W-1:0] trap_cause_i,
    input  logic [WIDTH-1:0]   mtvec_i,
    input  logic               mret_i,
    input  logic [WIDTH-1:0]   mepc_i,
    input  logic               halt_i,
    output logic               misalign_o,
    output logic [WIDTH-1:0]   misalign_addr_o
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    state_e             state_q, state_d;
    logic               boot_done_q;
    logic [WIDTH-1:0]   pc_q, pc_d, trap_base, trap_tgt, misalign_addr_q, misalign_addr_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               valid_q, valid_d, misalign_q, misalign_d, br_ok, redirect;

    always_comb begin
        trap_base       = mtvec_i & ~WIDTH'(3);
        // Vectored mode only applies to interrupts; exceptions always go to the base.
        trap_tgt        = (mtvec_i[1:0] == 2'b01 && trap_intr_i) ? trap_base + (WIDTH'(trap_cause_i) << 2) : trap_base;
        br_ok           = br_taken_i && br_target_i[1:0] == 2'b00;
        redirect        = trap_i || mret_i || br_ok;
        pc_d            = trap_i ? trap_tgt :
                          mret_i ? (mepc_i & ~WIDTH'(3)) :
                          br_ok ? br_target_i :
                          (valid_q && pc_ready_i) ? pc_q + WIDTH'(4) : pc_q;
        epoch_d         = redirect ? epoch_q + EPOCH_W'(1) : epoch_q;
        // A misaligned branch squashed by a higher-priority redirect is wrong-path and not reported.
        misalign_d      = br_taken_i && !trap_i && !mret_i && br_target_i[1:0] != 2'b00;
        misalign_addr_d = misalign_d ? br_target_i : misalign_addr_q;
        // BOOT spans the first full cycle after reset release, so it waits on boot_done_q.
        state_d         = state_q == BOOT ? (boot_done_q ? RUN : BOOT) :
                          trap_i ? RUN :
                          (state_q == RUN && halt_i) ? HALT : state_q;
        valid_d         = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= BOOT;
            boot_done_q     <= 1'b0;
            pc_q            <= RESET_VEC;
            epoch_q         <= '0;
            valid_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            boot_done_q     <= 1'b1;
            pc_q            <= pc_d;
            epoch_q         <= epoch_d;
            valid_q         <= valid_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign pc_o            = pc_q;
    assign epoch_o         = epoch_q;
    assign pc_valid_o      = valid_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen with a cycle-level reference model and randomized stimulus
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc_o, br_target_i = '0, mtvec_i = '0, mepc_i = '0, misalign_addr_o;
    logic [1:0]  epoch_o;
    logic        pc_valid_o, misalign_o;
    logic        pc_ready_i = 1'b1, br_taken_i = 1'b0, trap_i = 1'b0, trap_intr_i = 1'b0, mret_i = 1'b0, halt_i = 1'b0;
    logic [4:0]  trap_cause_i = '0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .epoch_o(epoch_o), .pc_valid_o(pc_valid_o),
        .pc_ready_i(pc_ready_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .trap_i(trap_i), .trap_intr_i(trap_intr_i), .trap_cause_i(trap_cause_i), .mtvec_i(mtvec_i),
        .mret_i(mret_i), .mepc_i(mepc_i), .halt_i(halt_i),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  ep;
        logic        v;
        logic        m;
        logic [31:0] ma;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    // Reference model: edges since reset release decide when fetching starts, a halted flag
    // freezes fetch, and each edge applies the highest-priority request.
    logic [31:0] m_pc, m_ma, tgt;
    logic [1:0]  m_ep;
    logic        m_mis, m_halt, m_valid;
    int          m_age;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pc = RV; m_ep = 0; m_mis = 0; m_ma = 0; m_halt = 0; m_age = 0;
            q.delete();
        end else begin
            m_valid = m_age >= 2 && !m_halt;
            m_mis   = 0;
            if (trap_i) begin
                tgt  = mtvec_i & ~32'h3;
                if (mtvec_i[1:0] == 2'b01 && trap_intr_i) tgt = tgt + 32'(trap_cause_i) * 4;
                m_pc = tgt; m_ep = m_ep + 1;
            end else if (mret_i) begin
                m_pc = mepc_i & ~32'h3; m_ep = m_ep + 1;
            end else if (br_taken_i && br_target_i % 4 == 0) begin
                m_pc = br_target_i; m_ep = m_ep + 1;
            end else begin
                if (br_taken_i) begin m_mis = 1; m_ma = br_target_i; end
                if (m_valid && pc_ready_i) m_pc = m_pc + 4;
            end
            if (trap_i) m_halt = 0;
            else if (m_valid && halt_i) m_halt = 1;
            if (m_age < 2) m_age++;
        end
        q.push_back('{pc: m_pc, ep: m_ep, v: (m_age >= 2 && !m_halt), m: m_mis, ma: m_ma});
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = q.pop_front();
            chk("pc", pc_o, e.pc);
            chk("epoch", 32'(epoch_o), 32'(e.ep));
            chk("valid", 32'(pc_valid_o), 32'(e.v));
            chk("misalign", 32'(misalign_o), 32'(e.m));
            chk("misalign_addr", misalign_addr_o, e.ma);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        br_taken_i = 0; trap_i = 0; mret_i = 0; halt_i = 0; trap_intr_i = 0;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            trap_i       = $urandom_range(0, 99) < 4;
            mret_i       = $urandom_range(0, 99) < 5;
            br_taken_i   = $urandom_range(0, 99) < 12;
            halt_i       = $urandom_range(0, 99) < 3;
            trap_intr_i  = 1'($urandom);
            trap_cause_i = 5'($urandom);
            mtvec_i      = $urandom;
            mepc_i       = $urandom;
            br_target_i  = $urandom;
            if ($urandom_range(0, 3) != 0) br_target_i[1:0] = 2'b00;
            pc_ready_i   = $urandom_range(0, 3) != 0;
            tick();
        end
        clr();
    endtask

    initial begin
        logic [31:0] frozen;
        tick(); tick();
        rst_n = 1;
        tick();
        chk("boot_valid", 32'(pc_valid_o), 0);
        chk("boot_pc", pc_o, RV);
        tick(); tick(); tick();
        chk("seq_pc", pc_o, 32'h8000_0008);
        chk("seq_valid", 32'(pc_valid_o), 1);
        tick(); tick();
        pc_ready_i = 0;
        tick(); tick(); tick();
        chk("stall_pc", pc_o, 32'h8000_0010);
        chk("stall_valid", 32'(pc_valid_o), 1);
        pc_ready_i = 1;
        tick();
        chk("resume_pc", pc_o, 32'h8000_0014);
        trap_i = 1; trap_intr_i = 1; trap_cause_i = 7; mtvec_i = 32'h8000_1001;
        mret_i = 1; mepc_i = 32'h1234_5678; br_taken_i = 1; br_target_i = 32'h8000_0200;
        tick(); clr();
        chk("prio_pc", pc_o, 32'h8000_101C);
        chk("prio_epoch", 32'(epoch_o), 1);
        br_taken_i = 1; br_target_i = 32'h8000_0102;
        tick(); clr();
        chk("mis_pc", pc_o, 32'h8000_1020);
        chk("mis_epoch", 32'(epoch_o), 1);
        chk("mis_pulse", 32'(misalign_o), 1);
        chk("mis_addr", misalign_addr_o, 32'h8000_0102);
        tick();
        chk("mis_drop", 32'(misalign_o), 0);
        for (int k = 0; k < 5; k++) begin
            br_taken_i = 1;
            br_target_i = (k == 4) ? 32'hFFFF_FFFC : 32'h8000_3000 + 32'(k) * 16;
            tick();
            chk("epoch_wrap", 32'(epoch_o), 32'((2 + k) % 4));
        end
        clr();
        tick();
        chk("pc_wrap", pc_o, 32'h0);
        halt_i = 1;
        tick(); clr();
        chk("halt_valid", 32'(pc_valid_o), 0);
        frozen = pc_o;
        tick(); tick();
        chk("halt_pc", pc_o, frozen);
        trap_i = 1; mtvec_i = 32'h8000_2000;
        tick(); clr();
        chk("unhalt_valid", 32'(pc_valid_o), 1);
        chk("unhalt_pc", pc_o, 32'h8000_2000);
        rand_cycles(400);
        br_taken_i = 1; br_target_i = 32'h0000_0123;
        tick(); clr();
        #2 rst_n = 0;
        #1;
        chk("arst_pc", pc_o, RV);
        chk("arst_epoch", 32'(epoch_o), 0);
        chk("arst_valid", 32'(pc_valid_o), 0);
        chk("arst_misalign", 32'(misalign_o), 0);
        chk("arst_misalign_addr", misalign_addr_o, 0);
        tick(); tick();
        rst_n = 1;
        rand_cycles(200);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
